// File: rtl/tt_sweep_ctrl.sv
// Truth-table sweep controller for a 3-input gate: walks all eight input
// vectors, samples the gate after a settle interval and compares against an expected code.
module tt_sweep_ctrl #(
  parameter int SETTLE = 4,
  parameter int CW     = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       abort,
  input  logic [7:0] tt_code,
  input  logic       dut_out,
  output logic       in1,
  output logic       in2,
  output logic       in3,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [7:0] observed_tt,
  output logic [7:0] mismatch_mask
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  localparam logic [CW-1:0] LP_CNT_LAST = CW'(SETTLE - 1);
  localparam logic [CW-1:0] LP_CNT_ONE  = CW'(1);

  state_t        r_state;
  logic [2:0]    r_idx;
  logic [CW-1:0] r_cnt;
  logic [7:0]    r_code;
  logic [7:0]    r_obs;
  logic [7:0]    r_mask;
  logic          r_pass;
  logic          r_done;
  logic          r_busy;
  logic [2:0]    r_in;

  logic [7:0]    w_obs_next;
  logic [7:0]    w_mask_next;

  // Index i of {in1,in2,in3} lands in code bit [7-i], so index 0 is the MSB.
  function automatic logic [7:0] f_capture(input logic [7:0] tt, input logic [2:0] idx,
                                           input logic bit_v);
    logic [7:0] v;
    v = tt;
    v[3'd7 - idx] = bit_v;
    return v;
  endfunction

  // Candidate table and mismatch for the capture happening at the current SAMPLE edge.
  always_comb begin
    w_obs_next  = f_capture(r_obs, r_idx, dut_out);
    w_mask_next = w_obs_next ^ r_code;
  end

  // Sweep sequencer; every output comes straight from a register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_idx   <= 3'd0;
      r_cnt   <= '0;
      r_code  <= 8'h00;
      r_obs   <= 8'h00;
      r_mask  <= 8'h00;
      r_pass  <= 1'b0;
      r_done  <= 1'b0;
      r_busy  <= 1'b0;
      r_in    <= 3'd0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_in   <= 3'd0;
          r_done <= 1'b0;
          // Abort takes priority over a simultaneous start request.
          if (start && !abort) begin
            r_code  <= tt_code;
            r_obs   <= 8'h00;
            r_mask  <= 8'h00;
            r_pass  <= 1'b0;
            r_idx   <= 3'd0;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_state <= ST_SETTLE;
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_SETTLE: begin
          r_done <= 1'b0;
          if (abort) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
            r_pass  <= 1'b0;
            r_mask  <= 8'h00;
            r_in    <= 3'd0;
            r_cnt   <= '0;
            r_idx   <= 3'd0;
          end else if (r_cnt == LP_CNT_LAST) begin
            r_cnt   <= '0;
            r_state <= ST_SAMPLE;
          end else begin
            r_cnt   <= r_cnt + LP_CNT_ONE;
          end
        end
        ST_SAMPLE: begin
          if (abort) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_pass  <= 1'b0;
            r_mask  <= 8'h00;
            r_in    <= 3'd0;
            r_cnt   <= '0;
            r_idx   <= 3'd0;
          end else if (r_idx == 3'd7) begin
            // Result is registered on the exit edge so it is valid alongside done.
            r_obs   <= w_obs_next;
            r_mask  <= w_mask_next;
            r_pass  <= (w_mask_next == 8'h00);
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= ST_DONE;
          end else begin
            r_obs   <= w_obs_next;
            r_idx   <= r_idx + 3'd1;
            r_in    <= r_idx + 3'd1;
            r_done  <= 1'b0;
            r_state <= ST_SETTLE;
          end
        end
        ST_DONE: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_in    <= 3'd0;
          r_idx   <= 3'd0;
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_in    <= 3'd0;
          r_cnt   <= '0;
          r_idx   <= 3'd0;
        end
      endcase
    end
  end

  assign in1           = r_in[2];
  assign in2           = r_in[1];
  assign in3           = r_in[0];
  assign busy          = r_busy;
  assign done          = r_done;
  assign pass          = r_pass;
  assign observed_tt   = r_obs;
  assign mismatch_mask = r_mask;

endmodule

// File: tb/tb_tt_sweep_ctrl.sv
// Directed bench for tt_sweep_ctrl: ideal, stuck-at-1 and delayed gate models,
// restart/abort/reset corner cases, plus a short-settle instance showing the settle requirement.
module tb_tt_sweep_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       start_a, abort_a, start_b, abort_b;
  logic [7:0] tt_code_a, tt_code_b;
  logic       dut_out_a, dut_out_b;
  logic       in1_a, in2_a, in3_a, in1_b, in2_b, in3_b;
  logic       busy_a, done_a, pass_a, busy_b, done_b, pass_b;
  logic [7:0] obs_a, mask_a, obs_b, mask_b;
  logic [2:0] in_a, in_b;
  logic [2:0] dly_a, dly_b;
  int         mode;
  int         n_total = 0;
  int         n_pass  = 0;
  int         n_fail  = 0;

  assign in_a = {in1_a, in2_a, in3_a};
  assign in_b = {in1_b, in2_b, in3_b};

  function automatic logic gate_b7(input logic [2:0] idx);
    logic [7:0] t;
    t = 8'hB7;
    return t[3'd7 - idx];
  endfunction

  // Three-stage registered model of the 0xB7 gate
  always @(posedge clk) begin
    dly_a <= {dly_a[1:0], gate_b7(in_a)};
    dly_b <= {dly_b[1:0], gate_b7(in_b)};
  end

  assign dut_out_a = (mode == 0) ? gate_b7(in_a) : (mode == 1) ? 1'b1 : dly_a[2];
  assign dut_out_b = dly_b[2];

  tt_sweep_ctrl #(.SETTLE(4), .CW(8)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .abort(abort_a), .tt_code(tt_code_a),
    .dut_out(dut_out_a), .in1(in1_a), .in2(in2_a), .in3(in3_a), .busy(busy_a),
    .done(done_a), .pass(pass_a), .observed_tt(obs_a), .mismatch_mask(mask_a)
  );

  tt_sweep_ctrl #(.SETTLE(2), .CW(8)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .abort(abort_b), .tt_code(tt_code_b),
    .dut_out(dut_out_b), .in1(in1_b), .in2(in2_b), .in3(in3_b), .busy(busy_b),
    .done(done_b), .pass(pass_b), .observed_tt(obs_b), .mismatch_mask(mask_b)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    assert (got === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Starts a sweep on instance A and follows it while busy; optional injections by busy cycle.
  task automatic run_sweep(input logic [7:0] code, input int inj_start, input int inj_abort,
                           input int inj_stop, output int bc, output int in_err,
                           output int done_err);
    bc = 0; in_err = 0; done_err = 0;
    @(negedge clk);
    start_a = 1'b1; tt_code_a = code;
    @(negedge clk);
    start_a = 1'b0;
    while (busy_a && bc < 200 && bc != inj_stop) begin
      if (in_a !== 3'(bc / 5)) in_err++;
      if (done_a !== 1'b0) done_err++;
      start_a = (bc == inj_start);
      if (bc == inj_start) tt_code_a = 8'h00;
      abort_a = (bc == inj_abort);
      bc++;
      @(negedge clk);
    end
    start_a = 1'b0;
    abort_a = 1'b0;
  endtask

  initial begin
    int bc, in_err, done_err, late_done;
    rst_n = 1'b0; start_a = 1'b0; abort_a = 1'b0; start_b = 1'b0; abort_b = 1'b0;
    tt_code_a = 8'h00; tt_code_b = 8'h00; mode = 0;
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(busy_a), 32'd0);
    check("rst_done", 32'(done_a), 32'd0);
    check("rst_pass", 32'(pass_a), 32'd0);
    check("rst_obs", 32'(obs_a), 32'h00);
    check("rst_mask", 32'(mask_a), 32'h00);
    check("rst_in", 32'(in_a), 32'd0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    // Ideal gate
    mode = 0;
    run_sweep(8'hB7, -1, -1, -1, bc, in_err, done_err);
    check("ideal_busy_cycles", 32'(bc), 32'd40);
    check("ideal_in_seq", 32'(in_err), 32'd0);
    check("ideal_early_done", 32'(done_err), 32'd0);
    check("ideal_done", 32'(done_a), 32'd1);
    check("ideal_obs", 32'(obs_a), 32'hB7);
    check("ideal_mask", 32'(mask_a), 32'h00);
    check("ideal_pass", 32'(pass_a), 32'd1);
    @(negedge clk);
    check("ideal_done_pulse", 32'(done_a), 32'd0);
    check("ideal_in_idle", 32'(in_a), 32'd0);
    check("ideal_pass_hold", 32'(pass_a), 32'd1);
    repeat (4) @(negedge clk);

    // Stuck-at-1 gate
    mode = 1;
    run_sweep(8'hB7, -1, -1, -1, bc, in_err, done_err);
    check("sa1_busy_cycles", 32'(bc), 32'd40);
    check("sa1_obs", 32'(obs_a), 32'hFF);
    check("sa1_mask", 32'(mask_a), 32'h48);
    check("sa1_pass", 32'(pass_a), 32'd0);
    repeat (4) @(negedge clk);

    // Registered 3-cycle gate with enough settle time
    mode = 2;
    run_sweep(8'hB7, -1, -1, -1, bc, in_err, done_err);
    check("dly4_obs", 32'(obs_a), 32'hB7);
    check("dly4_mask", 32'(mask_a), 32'h00);
    check("dly4_pass", 32'(pass_a), 32'd1);
    repeat (4) @(negedge clk);

    // Same gate with SETTLE=2: each vector sees the previous vector's response
    @(negedge clk);
    start_b = 1'b1; tt_code_b = 8'hB7;
    @(negedge clk);
    start_b = 1'b0;
    bc = 0;
    while (busy_b && bc < 200) begin
      bc++;
      @(negedge clk);
    end
    check("dly2_busy_cycles", 32'(bc), 32'd24);
    check("dly2_done", 32'(done_b), 32'd1);
    check("dly2_obs", 32'(obs_b), 32'hDB);
    check("dly2_mask", 32'(mask_b), 32'h6C);
    check("dly2_pass", 32'(pass_b), 32'd0);
    repeat (4) @(negedge clk);

    // Restart request with a different code mid-sweep is ignored
    mode = 0;
    run_sweep(8'hB7, 9, -1, -1, bc, in_err, done_err);
    check("restart_busy_cycles", 32'(bc), 32'd40);
    check("restart_in_seq", 32'(in_err), 32'd0);
    check("restart_obs", 32'(obs_a), 32'hB7);
    check("restart_mask", 32'(mask_a), 32'h00);
    check("restart_pass", 32'(pass_a), 32'd1);
    repeat (4) @(negedge clk);

    // Abort in the SAMPLE cycle of index 3
    run_sweep(8'hB7, -1, 19, -1, bc, in_err, done_err);
    check("abort_busy_cycles", 32'(bc), 32'd20);
    check("abort_in", 32'(in_a), 32'd0);
    check("abort_obs", 32'(obs_a), 32'hA0);
    check("abort_mask", 32'(mask_a), 32'h00);
    check("abort_pass", 32'(pass_a), 32'd0);
    late_done = done_err;
    for (int i = 0; i < 50; i++) begin
      if (done_a !== 1'b0) late_done++;
      @(negedge clk);
    end
    check("abort_no_done", 32'(late_done), 32'd0);

    // Abort and start together in IDLE
    start_a = 1'b1; abort_a = 1'b1; tt_code_a = 8'hB7;
    @(negedge clk);
    start_a = 1'b0; abort_a = 1'b0;
    check("abort_start_idle", 32'(busy_a), 32'd0);
    repeat (4) @(negedge clk);

    // Asynchronous reset mid-sweep
    run_sweep(8'hB7, -1, -1, 16, bc, in_err, done_err);
    check("rstmid_was_busy", 32'(busy_a), 32'd1);
    check("rstmid_partial_obs", 32'(obs_a), 32'hA0);
    rst_n = 1'b0;
    #1;
    check("rstmid_busy", 32'(busy_a), 32'd0);
    check("rstmid_in", 32'(in_a), 32'd0);
    check("rstmid_obs", 32'(obs_a), 32'h00);
    check("rstmid_done", 32'(done_a), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    run_sweep(8'hB7, -1, -1, -1, bc, in_err, done_err);
    check("post_rst_busy_cycles", 32'(bc), 32'd40);
    check("post_rst_done", 32'(done_a), 32'd1);
    check("post_rst_pass", 32'(pass_a), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
